// File: rtl/ssp_tx_dma_cntl.sv
// ssp_tx_dma_cntl: TX DMA request controller for a synchronous serial port.
// Raises single or burst requests to a DMA controller based on the TX FIFO
// fill level. It counts the writes accepted per request and flags protocol
// errors: overrun of the granted request, or a write dropped on a full FIFO.
module ssp_tx_dma_cntl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       TXDMAE,
  input  logic [3:0] TxFFillLevel,
  input  logic       TNF,
  input  logic       TxWrAccept,
  input  logic       SSPDRWr,
  input  logic       SSPTXDMACLR,
  input  logic       TxDmaErrClr,
  output logic       SSPTXDMASREQ,
  output logic       SSPTXDMABREQ,
  output logic       TxDmaErr,
  output logic [1:0] TxDmaState,
  output logic [3:0] TxBurstCnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SINGLE  = 2'd1,
    ST_BURST   = 2'd2,
    ST_WAITCLR = 2'd3
  } state_e;

  // A burst fits when free space (depth - level) covers a whole burst. The
  // level is compared unsigned, so an out-of-range level never qualifies.
  localparam logic [3:0] BURST_THRESH = 4'(FIFO_DEPTH - BURST_LEN);
  localparam logic [3:0] BURST_LIMIT  = 4'(BURST_LEN);
  localparam logic [3:0] SINGLE_LIMIT = 4'd1;
  localparam logic [3:0] CNT_MAX      = 4'd15;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       sreq_q, sreq_d;
  logic       breq_q, breq_d;

  logic       burst_ok_s;
  logic       active_s;
  logic [3:0] cnt_inc_s;
  logic [3:0] limit_s;
  logic       err_set_s;

  // Next-state, accept counter and error-set decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_set_s  = 1'b0;
    burst_ok_s = (TxFFillLevel <= BURST_THRESH);
    active_s   = (state_q == ST_SINGLE) || (state_q == ST_BURST);
    limit_s    = (state_q == ST_BURST) ? BURST_LIMIT : SINGLE_LIMIT;
    cnt_inc_s  = (TxWrAccept && (cnt_q != CNT_MAX)) ? (cnt_q + 4'd1) : cnt_q;

    if (!TXDMAE) begin
      // Disabling aborts any transfer silently: no error checks at all.
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (burst_ok_s) begin
            state_d = ST_BURST;
            cnt_d   = 4'd0;
          end else if (TNF) begin
            state_d = ST_SINGLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SINGLE, ST_BURST: begin
          cnt_d     = cnt_inc_s;
          // A write attempted but not accepted was dropped on a full FIFO.
          err_set_s = SSPDRWr && !TxWrAccept;
          if (SSPTXDMACLR) begin
            state_d = ST_WAITCLR;
            if (cnt_inc_s > limit_s) begin
              err_set_s = 1'b1;
            end else begin
              err_set_s = SSPDRWr && !TxWrAccept;
            end
          end else if ((state_q == ST_SINGLE) && !TNF) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end
        ST_WAITCLR: begin
          if (SSPTXDMACLR) begin
            state_d = ST_WAITCLR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    // A set condition in the same cycle beats an explicit clear.
    if (err_set_s) begin
      err_d = 1'b1;
    end else if (TxDmaErrClr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    sreq_d = (state_d == ST_SINGLE) || (state_d == ST_BURST);
    breq_d = (state_d == ST_BURST);
  end

  // State, counter, error flag and request outputs, all registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      sreq_q  <= 1'b0;
      breq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sreq_q  <= sreq_d;
      breq_q  <= breq_d;
    end
  end

  assign SSPTXDMASREQ = sreq_q;
  assign SSPTXDMABREQ = breq_q;
  assign TxDmaErr     = err_q;
  assign TxDmaState   = state_q;
  assign TxBurstCnt   = cnt_q;

endmodule

// File: tb/tb_ssp_tx_dma_cntl.sv
// Testbench for ssp_tx_dma_cntl. Directed scenarios followed by random
// stimulus. Every cycle is checked against a behavioural reference model.
module tb_ssp_tx_dma_cntl;

  localparam int DEPTH = 8;
  localparam int BLEN  = 4;

  logic       PCLK = 1'b0;
  logic       PRESET, TXDMAE, TNF, TxWrAccept, SSPDRWr, SSPTXDMACLR, TxDmaErrClr;
  logic [3:0] TxFFillLevel;
  logic       SSPTXDMASREQ, SSPTXDMABREQ, TxDmaErr;
  logic [1:0] TxDmaState;
  logic [3:0] TxBurstCnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (state codes 0..3 as in the requirements).
  int m_state = 0;
  int m_cnt   = 0;
  int m_err   = 0;

  ssp_tx_dma_cntl #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BLEN)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .TXDMAE(TXDMAE), .TxFFillLevel(TxFFillLevel),
    .TNF(TNF), .TxWrAccept(TxWrAccept), .SSPDRWr(SSPDRWr),
    .SSPTXDMACLR(SSPTXDMACLR), .TxDmaErrClr(TxDmaErrClr),
    .SSPTXDMASREQ(SSPTXDMASREQ), .SSPTXDMABREQ(SSPTXDMABREQ),
    .TxDmaErr(TxDmaErr), .TxDmaState(TxDmaState), .TxBurstCnt(TxBurstCnt)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the current inputs.
  task automatic model_edge();
    int set;
    int limit;
    set = 0;
    if (PRESET) begin
      m_state = 0; m_cnt = 0; m_err = 0;
    end else begin
      if (!TXDMAE) begin
        m_state = 0; m_cnt = 0;
      end else if (m_state == 0) begin
        if (int'(TxFFillLevel) <= DEPTH - BLEN) begin m_state = 2; m_cnt = 0; end
        else if (TNF) begin m_state = 1; m_cnt = 0; end
      end else if (m_state == 1 || m_state == 2) begin
        if (TxWrAccept) m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        if (SSPDRWr && !TxWrAccept) set = 1;
        if (SSPTXDMACLR) begin
          limit = (m_state == 1) ? 1 : BLEN;
          if (m_cnt > limit) set = 1;
          m_state = 3;
        end else if (m_state == 1 && !TNF) begin
          m_state = 0;
        end
      end else begin
        if (!SSPTXDMACLR) m_state = 0;
      end
      if (set != 0) m_err = 1;
      else if (TxDmaErrClr) m_err = 0;
    end
  endtask

  // One clock: update model at the edge, compare all outputs 1 time unit later.
  task automatic tick();
    @(posedge PCLK);
    model_edge();
    #1;
    chk("state", 32'(TxDmaState), 32'(m_state));
    chk("cnt",   32'(TxBurstCnt), 32'(m_cnt));
    chk("err",   32'(TxDmaErr),   32'(m_err));
    chk("sreq",  32'(SSPTXDMASREQ), 32'((m_state == 1 || m_state == 2) ? 1 : 0));
    chk("breq",  32'(SSPTXDMABREQ), 32'((m_state == 2) ? 1 : 0));
  endtask

  task automatic drive(input logic en, input logic [3:0] lvl, input logic tnf,
                       input logic acc, input logic wr, input logic clr, input logic eclr);
    TXDMAE = en; TxFFillLevel = lvl; TNF = tnf; TxWrAccept = acc;
    SSPDRWr = wr; SSPTXDMACLR = clr; TxDmaErrClr = eclr;
  endtask

  initial begin
    PRESET = 1'b1;
    drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(); tick();
    chk("rst_state", 32'(TxDmaState), 32'd0);
    chk("rst_sreq", 32'(SSPTXDMASREQ), 32'd0);

    // Burst: level 0 -> BURST, 4 accepts, CLR -> WAITCLR, no error, IDLE.
    PRESET = 1'b0;
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("burst_breq", 32'(SSPTXDMABREQ), 32'd1);
    chk("burst_sreq", 32'(SSPTXDMASREQ), 32'd1);
    chk("burst_cnt0", 32'(TxBurstCnt), 32'd0);
    drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    chk("burst_cnt4", 32'(TxBurstCnt), 32'd4);
    drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("burst_clr_state", 32'(TxDmaState), 32'd3);
    chk("burst_clr_breq", 32'(SSPTXDMABREQ), 32'd0);
    chk("burst_clr_err", 32'(TxDmaErr), 32'd0);
    drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("burst_idle", 32'(TxDmaState), 32'd0);

    // Single: level 6 -> SINGLE, 2 accepts, CLR -> error, then clear it.
    drive(1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("single_sreq", 32'(SSPTXDMASREQ), 32'd1);
    chk("single_breq", 32'(SSPTXDMABREQ), 32'd0);
    drive(1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("single_overrun_err", 32'(TxDmaErr), 32'd1);
    drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("single_errclr", 32'(TxDmaErr), 32'd0);

    // Full: SINGLE with TNF low -> IDLE; dropped write during BURST -> error.
    drive(1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full_single", 32'(TxDmaState), 32'd1);
    drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("full_sreq", 32'(SSPTXDMASREQ), 32'd0);
    chk("full_idle", 32'(TxDmaState), 32'd0);
    tick();
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("drop_err", 32'(TxDmaErr), 32'd1);

    // Disable mid-burst with count 2: IDLE, count 0, no new error.
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    chk("dis_cnt2", 32'(TxBurstCnt), 32'd2);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("dis_idle", 32'(TxDmaState), 32'd0);
    chk("dis_cnt0", 32'(TxBurstCnt), 32'd0);
    chk("dis_noerr", 32'(TxDmaErr), 32'd0);

    // Reset mid-burst with error set, then restart.
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rst_pre_err", 32'(TxDmaErr), 32'd1);
    PRESET = 1'b1;
    drive(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rst_mid_err", 32'(TxDmaErr), 32'd0);
    chk("rst_mid_breq", 32'(SSPTXDMABREQ), 32'd0);
    chk("rst_mid_cnt", 32'(TxBurstCnt), 32'd0);
    PRESET = 1'b0;
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_rel_breq", 32'(SSPTXDMABREQ), 32'd1);

    // CLR held three cycles: WAITCLR throughout, IDLE one cycle after release.
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      chk("clrhold_state", 32'(TxDmaState), 32'd3);
      chk("clrhold_sreq", 32'(SSPTXDMASREQ), 32'd0);
    end
    drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("clrhold_idle", 32'(TxDmaState), 32'd0);

    // Threshold boundary: level 4 qualifies for a burst, level 5 does not.
    drive(1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lvl4_burst", 32'(TxDmaState), 32'd2);
    drive(1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("lvl5_single", 32'(TxDmaState), 32'd1);

    // Random phase against the reference model.
    for (int i = 0; i < 600; i++) begin
      PRESET = ($urandom_range(0, 60) == 0);
      drive(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssp_tx_dma_cntl.md
SSP_TX_DMA_CNTL -- requirements
Module: ssp_tx_dma_cntl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO depth in entries.
REQ-002 SHALL have parameter BURST_LEN, default 4: entries per burst request; legal range 1..FIFO_DEPTH.
REQ-003 SHALL have ports:
- PCLK  in  1  APB clock; sole clock.
- PRESET  in  1  reset, synchronous, active-high.
- TXDMAE  in  1  TX DMA enable.
- TxFFillLevel  in  4  TX FIFO fill level, 0..FIFO_DEPTH.
- TNF  in  1  TX FIFO not full.
- TxWrAccept  in  1  FIFO write accepted this cycle.
- SSPDRWr  in  1  FIFO write attempted this cycle.
- SSPTXDMACLR  in  1  DMA request clear from DMA controller.
- TxDmaErrClr  in  1  clears TxDmaErr.
- SSPTXDMASREQ  out  1  single-transfer request.
- SSPTXDMABREQ  out  1  burst-transfer request.
- TxDmaErr  out  1  sticky error flag.
- TxDmaState  out  2  current FSM state.
- TxBurstCnt  out  4  writes accepted in the current request.

Function
REQ-004 SHALL implement FSM states IDLE=0, SINGLE=1, BURST=2, WAITCLR=3, with all outputs registered.
REQ-005 IDLE -> BURST when TXDMAE=1 and TxFFillLevel <= FIFO_DEPTH-BURST_LEN; next cycle SREQ=1, BREQ=1, TxBurstCnt=0.
REQ-006 IDLE -> SINGLE when TXDMAE=1, TNF=1 and the burst condition is false; next cycle SREQ=1, BREQ=0, TxBurstCnt=0.
REQ-007 IDLE with TXDMAE=0 or TNF=0 SHALL stay IDLE with SREQ=BREQ=0.
REQ-008 In SINGLE or BURST, each cycle with TxWrAccept=1 SHALL increment TxBurstCnt, saturating at 15.
REQ-009 SINGLE or BURST with SSPTXDMACLR=1 -> WAITCLR; SREQ and BREQ SHALL be 0 from the next cycle.
REQ-010 On the REQ-009 transition, TxDmaErr SHALL set if the count including the current cycle's accept:
- exceeds 1 in SINGLE; or
- exceeds BURST_LEN in BURST.
REQ-011 WAITCLR -> IDLE on the first cycle SSPTXDMACLR=0, so requests are low for at least one cycle between transfers.
REQ-012 SINGLE with TNF=0 and SSPTXDMACLR=0 -> IDLE; SREQ deasserts next cycle.
REQ-013 TXDMAE=0 in any state -> IDLE next cycle, SREQ=BREQ=0, TxBurstCnt=0, with no error check; this has priority over REQ-009 to REQ-012.
REQ-014 SSPDRWr=1 with TxWrAccept=0 while in SINGLE or BURST SHALL set TxDmaErr (write to a full FIFO dropped).
REQ-015 TxDmaErr SHALL clear when TxDmaErrClr=1; a set condition in the same cycle wins.
REQ-016 TxFFillLevel SHALL be compared unsigned at 4 bits; values above FIFO_DEPTH are treated as full.

Reset
REQ-017 PRESET=1 at a PCLK edge SHALL force IDLE, SREQ=0, BREQ=0, TxDmaErr=0, TxBurstCnt=0, TxDmaState=0, regardless of other inputs, including mid-burst.
REQ-018 On the first edge with PRESET=0, the FSM SHALL evaluate REQ-005 to REQ-007 normally.

Verification
REQ-019 Bench SHALL cover these scenarios:
- Burst: level=0, TXDMAE=1 -> BREQ=SREQ=1 one cycle later; 4 accepts, then CLR pulse -> requests 0 next cycle, TxDmaErr=0, state WAITCLR then IDLE.
- Single: level=6 (free=2<4), TXDMAE=1 -> SREQ=1, BREQ=0; 2 accepts, then CLR -> TxDmaErr=1; TxDmaErrClr pulse -> TxDmaErr=0.
- Full: in SINGLE, level=8, TNF=0 -> SREQ=0 next cycle, state IDLE; SSPDRWr=1 with TxWrAccept=0 during BURST -> TxDmaErr=1.
- Disable: TXDMAE dropped mid-BURST with TxBurstCnt=2 -> IDLE next cycle, count=0, no error.
- Reset: PRESET asserted mid-BURST with TxDmaErr=1 -> all outputs 0 next edge; after release with level=0, BREQ=1 one cycle later.
- CLR held: SSPTXDMACLR held high 3 cycles -> FSM stays in WAITCLR, requests 0, IDLE one cycle after CLR falls.
